sw_seq_reader: RTL and testbench
================================

Name: sw_seq_reader

Overview:
- Read-side controller for the sequence buffer FIFO in the Smith-Waterman datapath.
- On a start command it drains exactly seq_len symbols from the FIFO by issuing read strobes, and streams them to the systolic PE array on a valid/ready interface.
- Marks the final symbol with last and pulses done once that symbol has been accepted.
- A 2-entry output buffer gives one symbol per cycle throughput with no combinational path from out_ready to fifo_rd.

Parameters:
DATA_WIDTH, 8, symbol width in bits (ASCII-coded base; 0x00 never a valid symbol)
LEN_WIDTH, 7, width of seq_len; maximum sequence length is 2**LEN_WIDTH-1

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle command; honoured only in IDLE
abort  input  1  synchronous cancel; valid in any state
seq_len  input  LEN_WIDTH  number of symbols to read; sampled when start is accepted
fifo_empty  input  1  FIFO has no unread entry
fifo_rdata  input  DATA_WIDTH  FIFO read data; combinational from current read pointer
fifo_en  output  1  FIFO enable; asserted whenever fifo_rd is asserted
fifo_rd  output  1  FIFO read strobe; pops one entry
out_valid  output  1  out_data holds a symbol
out_ready  input  1  downstream accepts when out_valid and out_ready are both high
out_data  output  DATA_WIDTH  symbol to PE array
out_last  output  1  qualifies out_data as final symbol of the sequence
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at sequence completion
err_unwritten  output  1  sticky zero-symbol flag (see Optional Feature)

Behaviour:
- Reset values: fifo_en, fifo_rd, out_valid, out_last, busy, done, err_unwritten = 0; out_data = 0; buffer empty; counters 0; state IDLE.
- States:
  - IDLE: start=1 latches seq_len into remain and goes to RUN. If seq_len=0, goes to DONE instead and issues no reads. start is ignored in all other states.
  - RUN:
    - fifo_rd = (remain != 0) & !fifo_empty & (buf_cnt < 2). The combinational expression is registered-free; no out_ready term.
    - In a read cycle, fifo_rdata is captured into the buffer tail at the same edge and remain decrements.
    - The captured entry carries a last tag, set when remain==1 at capture.
    - Goes to DRAIN when remain reaches 0.
  - DRAIN: no reads. Goes to DONE in the cycle the last-tagged entry is accepted.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- Buffer:
  - 2-entry FIFO with head/tail and buf_cnt in 0..2.
  - out_valid = (buf_cnt != 0); out_data and out_last come from the head.
  - A capture and an accept in the same cycle leave buf_cnt unchanged.
  - Order is preserved.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready=1 and the FIFO non-empty, one symbol per cycle. The first out_valid appears 2 cycles after start (1 cycle IDLE→RUN, 1 cycle capture).
- fifo_empty high mid-run: reads stall and remain is held. There is no timeout.
- abort:
  - Has priority over every transition.
  - Clears the buffer, remain, and out_valid, and returns to IDLE next cycle.
  - Raises no done pulse.
  - fifo_rd is forced 0 in the abort cycle.
- Asynchronous reset mid-operation: immediate return to reset values. FIFO entries already popped are lost.
- start and abort in the same cycle: abort wins; remains IDLE.

Optional Feature:
- Macro: SW_SEQ_READER_ZERO_CHECK_EN.
- Defined:
  - err_unwritten sets to 1 at the edge where a captured fifo_rdata == 0.
  - It stays set until reset or the next accepted start.
  - Data still flows unchanged.
- Undefined: err_unwritten is tied 0 and no compare logic exists.

Test Plan:
- Reset, then start with seq_len=4 and FIFO preloaded "ACGT", out_ready=1 → fifo_rd high 4 consecutive cycles; out_data 0x41,0x43,0x47,0x54 on consecutive cycles from cycle 2; out_last only with 0x54; done one cycle after the 0x54 accept.
- seq_len=3, out_ready low 5 cycles after start → exactly 2 reads then stall; buffer holds 0x41,0x43 stably; on release all 3 delivered in order with no duplication.
- fifo_empty asserted for 3 cycles mid-sequence with seq_len=5 → fifo_rd=0 during the gap; remain held; 5 symbols delivered; single done pulse.
- seq_len=0 start → no fifo_rd ever; done pulse 1 cycle after start; out_valid stays 0.
- abort with 2 symbols buffered and remain=3 → next cycle out_valid=0, busy=0, no done; new start with seq_len=2 reads the next 2 FIFO entries correctly.
- With SW_SEQ_READER_ZERO_CHECK_EN defined, FIFO entry 2 = 0x00 → err_unwritten rises at that capture and stays set until the next accepted start; without the macro it stays 0.

Source files
------------

// File: rtl/sw_seq_reader.sv
// -----------------------------------------------------------------------------
// sw_seq_reader
// Read-side controller for the Smith-Waterman sequence buffer FIFO. On start it
// pops exactly seq_len symbols and streams them to the systolic PE array on a
// valid/ready interface, tagging the final symbol with out_last and pulsing
// done once that symbol has been accepted downstream.
//
// A 2-entry output buffer decouples the FIFO read strobe from out_ready, so
// fifo_rd never depends combinationally on out_ready yet one symbol per cycle
// still flows when the consumer is always ready.
//
// Optional feature macro: SW_SEQ_READER_ZERO_CHECK_EN
//   defined   : err_unwritten is a sticky flag set whenever a captured symbol
//               is 0x00 (an unwritten FIFO slot); cleared by reset or the next
//               accepted start.
//   undefined : err_unwritten is tied 0.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   start          one-cycle start command (honoured in IDLE only)
//   abort          synchronous cancel, any state, highest priority
//   seq_len        symbols to read, sampled on accepted start
//   fifo_empty     FIFO has no unread entry
//   fifo_rdata     FIFO data at current read pointer (combinational)
//   fifo_en        FIFO enable, mirrors fifo_rd
//   fifo_rd        FIFO pop strobe
//   out_valid      out_data holds a symbol
//   out_ready      downstream accept
//   out_data       symbol to PE array
//   out_last       final symbol of the sequence
//   busy           high in RUN and DRAIN
//   done           one-cycle completion pulse
//   err_unwritten  sticky zero-symbol flag
// -----------------------------------------------------------------------------
module sw_seq_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  seq_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_en,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unwritten
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_buf_cnt;
  logic                  w_rd;
  logic                  w_accept;
  logic                  w_start_ok;

  assign out_valid = (r_buf_cnt != 2'd0);
  assign out_data  = r_buf_data[r_head];
  // Gate with valid so a stale tag left in the head slot is never exposed.
  assign out_last  = out_valid & r_buf_last[r_head];
  assign w_accept  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_state_next = r_state;
    w_rd         = 1'b0;
    w_start_ok   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = (seq_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Depends only on registered state and fifo_empty: no out_ready term.
        w_rd = (r_remain != '0) & ~fifo_empty & (r_buf_cnt < 2'd2);
        if (w_rd && (r_remain == LEN_WIDTH'(1))) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_accept && r_buf_last[r_head]) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_rd         = 1'b0;
      w_start_ok   = 1'b0;
      done         = 1'b0;
    end
  end

  assign fifo_rd = w_rd;
  assign fifo_en = w_rd;

  // Remaining count and 2-entry output buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remain   <= '0;
      r_buf_last <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_buf_cnt  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
      end
    end else if (abort) begin
      r_remain  <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_buf_cnt <= 2'd0;
    end else begin
      if (w_start_ok) begin
        r_remain <= seq_len;
      end
      if (w_rd) begin
        r_buf_data[r_tail] <= fifo_rdata;
        r_buf_last[r_tail] <= (r_remain == LEN_WIDTH'(1));
        r_tail             <= ~r_tail;
        r_remain           <= r_remain - LEN_WIDTH'(1);
      end
      if (w_accept) begin
        r_head <= ~r_head;
      end
      // Simultaneous capture and accept leave the occupancy unchanged.
      case ({w_rd, w_accept})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

`ifdef SW_SEQ_READER_ZERO_CHECK_EN
  logic r_err;

  // Start and capture never coincide (capture only happens in RUN).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_rd && (fifo_rdata == '0)) begin
      r_err <= 1'b1;
    end
  end

  assign err_unwritten = r_err;
`else
  assign err_unwritten = 1'b0;
`endif

endmodule

// File: tb/tb_sw_seq_reader.sv
module tb_sw_seq_reader;

  localparam int DW = 8;
  localparam int LW = 7;
`ifdef SW_SEQ_READER_ZERO_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [LW-1:0] seq_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_en;
  logic          fifo_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err_unwritten;

  sw_seq_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .seq_len      (seq_len),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_en      (fifo_en),
    .fifo_rd      (fifo_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_unwritten(err_unwritten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple FIFO model: the bench appends entries, the DUT pops them.
  logic [DW-1:0] fmem [64];
  int            frd = 0;
  int            fwr = 0;
  logic          force_empty;

  assign fifo_rdata = fmem[frd[5:0]];
  assign fifo_empty = (frd == fwr) | force_empty;

  always @(posedge clk) begin
    if (fifo_rd) frd <= frd + 1;
  end

  typedef struct packed {
    logic          st;
    logic          ab;
    logic [LW-1:0] len;
    logic          rdy;
    logic          emp;
    logic          e_rd;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_last;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t tbl [80];
  int   ntbl = 0;
  int   total = 0;
  int   bad = 0;
  int   cur_row = -1;
  int   exp_pops = 0;

  task automatic add(input logic st, input logic ab, input logic [LW-1:0] len,
                     input logic rdy, input logic emp, input logic e_rd,
                     input logic e_valid, input logic [DW-1:0] e_data,
                     input logic e_last, input logic e_busy, input logic e_done,
                     input logic e_err);
    tbl[ntbl] = '{st, ab, len, rdy, emp, e_rd, e_valid, e_data, e_last,
                  e_busy, e_done, e_err};
    ntbl++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL row=%0d %s got=%0h exp=%0h", cur_row, nm, got, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    fmem[fwr[5:0]] = d;
    fwr++;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      start       = tbl[i].st;
      abort       = tbl[i].ab;
      seq_len     = tbl[i].len;
      out_ready   = tbl[i].rdy;
      force_empty = tbl[i].emp;
      #1;
      cur_row = i;
      chk("fifo_rd", 32'(fifo_rd), 32'(tbl[i].e_rd));
      chk("fifo_en", 32'(fifo_en), 32'(tbl[i].e_rd));
      chk("out_valid", 32'(out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("out_data", 32'(out_data), 32'(tbl[i].e_data));
      chk("out_last", 32'(out_last), 32'(tbl[i].e_last));
      chk("busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("done", 32'(done), 32'(tbl[i].e_done));
      chk("err_unwritten", 32'(err_unwritten), 32'(tbl[i].e_err));
      $display("row %0d: st=%0b ab=%0b len=%0d rdy=%0b emp=%0b | rd=%0b v=%0b d=%02h l=%0b busy=%0b done=%0b err=%0b",
               i, start, abort, seq_len, out_ready, force_empty, fifo_rd,
               out_valid, out_data, out_last, busy, done, err_unwritten);
    end
  endtask

  int t1, t2, t3, t4, t5, t6, t7, t8;

  initial begin
    // ---------------- vector table ----------------
    // Test 1: "ACGT", seq_len=4, always ready
    t1 = ntbl;
    add(1,0,4,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h41,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h43,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h47,0,1,0,0);
    add(0,0,0,1,0, 0,1,8'h54,1,1,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 2: seq_len=3, out_ready low for 5 cycles
    t2 = ntbl;
    add(1,0,3,0,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,0,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,0,0, 1,1,8'h41,0,1,0,0);
    add(0,0,0,0,0, 0,1,8'h41,0,1,0,0);
    add(0,0,0,0,0, 0,1,8'h41,0,1,0,0);
    add(0,0,0,1,0, 0,1,8'h41,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h43,0,1,0,0);
    add(0,0,0,1,0, 0,1,8'h47,1,1,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 3: seq_len=5, fifo_empty for 3 cycles mid-run
    t3 = ntbl;
    add(1,0,5,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h41,0,1,0,0);
    add(0,0,0,1,1, 0,1,8'h42,0,1,0,0);
    add(0,0,0,1,1, 0,0,8'h00,0,1,0,0);
    add(0,0,0,1,1, 0,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h43,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h44,0,1,0,0);
    add(0,0,0,1,0, 0,1,8'h45,1,1,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 4: seq_len=0
    t4 = ntbl;
    add(1,0,0,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 5: abort with 2 buffered, remain=3; then restart seq_len=2
    t5 = ntbl;
    add(1,0,5,0,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,0,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,0,0, 1,1,8'h41,0,1,0,0);
    add(0,1,0,0,0, 0,1,8'h41,0,1,0,0);
    add(1,0,2,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h43,0,1,0,0);
    add(0,0,0,1,0, 0,1,8'h44,1,1,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 6: start+abort together; abort in a cycle that would read
    t6 = ntbl;
    add(1,1,3,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    add(1,0,3,1,0, 0,0,8'h00,0,0,0,0);
    add(0,1,0,1,0, 0,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    // Test 7: zero symbol in entry 2; cleared by next accepted start
    t7 = ntbl;
    add(1,0,3,1,0, 0,0,8'h00,0,0,0,0);
    add(0,0,0,1,0, 1,0,8'h00,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h41,0,1,0,0);
    add(0,0,0,1,0, 1,1,8'h00,0,1,0,ERR_EN);
    add(0,0,0,1,0, 0,1,8'h43,1,1,0,ERR_EN);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,ERR_EN);
    add(1,0,0,1,0, 0,0,8'h00,0,0,0,ERR_EN);
    add(0,0,0,1,0, 0,0,8'h00,0,0,1,0);
    add(0,0,0,1,0, 0,0,8'h00,0,0,0,0);
    t8 = ntbl;

    // ---------------- reset ----------------
    reset = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
    out_ready = 1'b0; force_empty = 1'b0;
    for (int i = 0; i < 64; i++) fmem[i] = 8'h00;
    #2;
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_fifo_en", 32'(fifo_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_unwritten), 0);
    $display("reset: rd=%0b v=%0b d=%02h busy=%0b done=%0b err=%0b",
             fifo_rd, out_valid, out_data, busy, done, err_unwritten);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ---------------- table tests ----------------
    load(8'h41); load(8'h43); load(8'h47); load(8'h54);
    run_rows(t1, t2); exp_pops += 4; chk("pops_t1", 32'(frd), 32'(exp_pops));
    load(8'h41); load(8'h43); load(8'h47);
    run_rows(t2, t3); exp_pops += 3; chk("pops_t2", 32'(frd), 32'(exp_pops));
    load(8'h41); load(8'h42); load(8'h43); load(8'h44); load(8'h45);
    run_rows(t3, t4); exp_pops += 5; chk("pops_t3", 32'(frd), 32'(exp_pops));
    run_rows(t4, t5); chk("pops_t4", 32'(frd), 32'(exp_pops));
    load(8'h41); load(8'h42); load(8'h43); load(8'h44);
    run_rows(t5, t6); exp_pops += 4; chk("pops_t5", 32'(frd), 32'(exp_pops));
    load(8'h41); load(8'h00); load(8'h43);
    run_rows(t6, t7); chk("pops_t6", 32'(frd), 32'(exp_pops));
    run_rows(t7, t8); exp_pops += 3; chk("pops_t7", 32'(frd), 32'(exp_pops));

    // ---------------- asynchronous reset mid-run ----------------
    cur_row = -2;
    load(8'h57); load(8'h58); load(8'h59); load(8'h5A);
    @(negedge clk); start = 1'b1; seq_len = 7'd4; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_pre_valid", 32'(out_valid), 1);
    chk("ar_pre_data", 32'(out_data), 32'h57);
    chk("ar_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_fifo_rd", 32'(fifo_rd), 0);
    $display("async reset: v=%0b d=%02h busy=%0b rd=%0b", out_valid, out_data, busy, fifo_rd);
    exp_pops += 2;
    chk("pops_ar", 32'(frd), 32'(exp_pops));
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("ar_post_busy", 32'(busy), 0);
    chk("ar_post_valid", 32'(out_valid), 0);
    chk("ar_post_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
